mmm_bit_serial: RTL
===================

MMM_BIT_SERIAL -- requirements
Module: mmm_bit_serial

Interface
REQ-001 SHALL have parameter WIDTH, default 8, meaning operand/modulus bit width.
REQ-002 SHALL have port clk  input  1  rising-edge clock.
REQ-003 SHALL have port rstb  input  1  reset, synchronous, active-low.
REQ-004 SHALL have port ena  input  1  clock enable; 0 freezes all state.
REQ-005 SHALL have port clear  input  1  active-low synchronous soft clear, driven by the exponentiation controller's clear_mmm.
REQ-006 SHALL have port start  input  1  request; sampled only in IDLE.
REQ-007 SHALL have ports a_in, b_in, m_in  input  WIDTH  multiplicand, multiplier, odd modulus.
REQ-008 SHALL have port busy  output  1  high in any state except IDLE.
REQ-009 SHALL have port done  output  1  one-cycle completion pulse.
REQ-010 SHALL have port p_out  output  WIDTH  result A*B*2^-WIDTH mod M, held until next done.
REQ-011 SHALL have port err  output  1  operand-check failure, valid with done.

Function
REQ-012 SHALL implement states IDLE, ITER, SUB.
REQ-013 SHALL, in IDLE with start=1 at an edge, capture a_in, b_in and m_in into internal registers, clear accumulator R (WIDTH+2 bits) and step counter, and enter ITER.
REQ-014 SHALL, per ITER edge with bit a=A[0]: q=R[0]^(a&B[0]); R=(R+a*B+q*M)>>1; A>>=1; counter+1.
REQ-015 SHALL leave ITER for SUB after exactly WIDTH iterations; counter width $clog2(WIDTH+1).
REQ-016 SHALL, in SUB, load p_out=R-M if R>=M else R[WIDTH-1:0], pulse done=1 (registered), return to IDLE.
REQ-017 SHALL assert done exactly WIDTH+1 enabled edges after the start-sampling edge; done is high for one enabled cycle.
REQ-018 SHALL ignore start while busy; start in the same cycle done is high is accepted (IDLE).
REQ-019 SHALL, with ena=0, hold state, registers, and outputs (done stays at its current value).
REQ-020 SHALL, on clear=0 with ena=1, force IDLE, zero R, counter, done, and err; p_out is retained; clear dominates start.
REQ-021 SHALL keep every intermediate sum within WIDTH+2 bits without overflow (R<2M invariant).

Reset
REQ-022 SHALL, on rstb=0 at a clock edge, set state IDLE and zero R, operand registers, counter, p_out, done, err; busy=0.
REQ-023 SHALL give reset priority over ena and clear; reset mid-operation abandons the computation with no done.

Configuration
REQ-024 SHALL, with MMM_OPERAND_CHECK_EN defined, at the start edge flag m_in[0]=0, a_in>=m_in, or b_in>=m_in: skip ITER/SUB, pulse done with err=1 on the next enabled edge, leave p_out unchanged.
REQ-025 SHALL, without MMM_OPERAND_CHECK_EN, tie err to 0 and compute unconditionally (result undefined for illegal operands).

Structure
REQ-026 SHALL place the state enum type in the shared package rsa_pkg.
REQ-027 SHALL implement one iteration (REQ-014 datapath) as combinational sub-module mmm_iter_step.

Verification (WIDTH=8)
REQ-028 SHALL check A=5, B=7, M=13 -> p_out=1, done exactly 9 enabled edges after the start edge, busy high in between.
REQ-029 SHALL check A=250, B=250, M=251 -> p_out=201 (final-subtraction path).
REQ-030 SHALL check A=1, B=1, M=255 -> p_out=1; A=0, B=77, M=255 -> p_out=0.
REQ-031 SHALL check clear=0 at iteration 4 -> busy=0 next cycle, no done, p_out unchanged; ena=0 for 3 cycles mid-run -> done delayed by exactly 3 cycles with result unchanged.
REQ-032 SHALL check that a second start while busy is ignored and that start held with done=1 begins a back-to-back operation.
REQ-033 SHALL check, with MMM_OPERAND_CHECK_EN, M=12 -> done and err=1 on the next enabled edge, p_out unchanged; without it, err=0 always.

Source files
------------

// File: rtl/rsa_pkg.sv
// Shared types for the RSA datapath blocks: Montgomery multiplier state encoding.
package rsa_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ITER = 2'd1,
    ST_SUB  = 2'd2
  } mmm_state_e;

endpackage : rsa_pkg

// File: rtl/mmm_iter_step.sv
// One radix-2 Montgomery iteration: R' = (R + a*B + q*M) >> 1, with q chosen so the sum is even.
module mmm_iter_step
  import rsa_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH+1:0] r,
  input  logic             a_bit,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] m,
  output logic [WIDTH+1:0] r_next
);

  logic             q_s;
  logic [WIDTH+1:0] add_b_s;
  logic [WIDTH+1:0] add_m_s;
  logic [WIDTH+1:0] sum_s;

  assign q_s     = r[0] ^ (a_bit & b[0]);
  assign add_b_s = a_bit ? {2'b00, b} : {(WIDTH+2){1'b0}};
  assign add_m_s = q_s   ? {2'b00, m} : {(WIDTH+2){1'b0}};
  // With R < 2M and B < M the sum stays below 4M, so WIDTH+2 bits never overflow.
  assign sum_s   = r + add_b_s + add_m_s;
  assign r_next  = {1'b0, sum_s[WIDTH+1:1]};

endmodule : mmm_iter_step

// File: rtl/mmm_bit_serial.sv
// Bit-serial Montgomery multiplier: p_out = A*B*2^-WIDTH mod M in WIDTH+1 enabled cycles.
// Optional operand checking is enabled by defining MMM_OPERAND_CHECK_EN.
module mmm_bit_serial
  import rsa_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rstb,
  input  logic             ena,
  input  logic             clear,
  input  logic             start,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic [WIDTH-1:0] m_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] p_out,
  output logic             err
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  mmm_state_e       state_r;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  logic [WIDTH-1:0] m_r;
  logic [WIDTH+1:0] r_r;
  logic [CW-1:0]    cnt_r;
  logic [WIDTH-1:0] p_out_r;
  logic             done_r;
  logic             err_r;
  logic             bad_r;

  logic [WIDTH+1:0] r_next_s;
  logic [WIDTH+1:0] r_sub_s;
  logic             r_ge_m_s;
  logic             illegal_s;

  mmm_iter_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .r      (r_r),
    .a_bit  (a_r[0]),
    .b      (b_r),
    .m      (m_r),
    .r_next (r_next_s)
  );

  assign r_ge_m_s = (r_r >= {2'b00, m_r});
  assign r_sub_s  = r_r - {2'b00, m_r};

`ifdef MMM_OPERAND_CHECK_EN
  assign illegal_s = ~m_in[0] | (a_in >= m_in) | (b_in >= m_in);
`else
  assign illegal_s = 1'b0;
`endif

  // Control FSM, datapath registers and registered outputs.
  always_ff @(posedge clk) begin
    if (!rstb) begin
      state_r <= ST_IDLE;
      a_r     <= {WIDTH{1'b0}};
      b_r     <= {WIDTH{1'b0}};
      m_r     <= {WIDTH{1'b0}};
      r_r     <= {(WIDTH+2){1'b0}};
      cnt_r   <= {CW{1'b0}};
      p_out_r <= {WIDTH{1'b0}};
      done_r  <= 1'b0;
      err_r   <= 1'b0;
      bad_r   <= 1'b0;
    end else if (ena) begin
      if (!clear) begin
        state_r <= ST_IDLE;
        r_r     <= {(WIDTH+2){1'b0}};
        cnt_r   <= {CW{1'b0}};
        done_r  <= 1'b0;
        err_r   <= 1'b0;
        bad_r   <= 1'b0;
      end else begin
        done_r <= 1'b0;
        err_r  <= 1'b0;
        case (state_r)
          ST_IDLE: begin
            if (start) begin
              a_r     <= a_in;
              b_r     <= b_in;
              m_r     <= m_in;
              r_r     <= {(WIDTH+2){1'b0}};
              cnt_r   <= {CW{1'b0}};
              bad_r   <= illegal_s;
              // Rejected operands skip the iterations and report on the next edge.
              state_r <= illegal_s ? ST_SUB : ST_ITER;
            end
          end
          ST_ITER: begin
            r_r   <= r_next_s;
            a_r   <= {1'b0, a_r[WIDTH-1:1]};
            cnt_r <= cnt_r + {{(CW-1){1'b0}}, 1'b1};
            if (cnt_r == CNT_LAST) begin
              state_r <= ST_SUB;
            end
          end
          ST_SUB: begin
            done_r <= 1'b1;
            if (bad_r) begin
              err_r <= 1'b1;
            end else if (r_ge_m_s) begin
              p_out_r <= r_sub_s[WIDTH-1:0];
            end else begin
              p_out_r <= r_r[WIDTH-1:0];
            end
            bad_r   <= 1'b0;
            state_r <= ST_IDLE;
          end
          default: begin
            state_r <= ST_IDLE;
          end
        endcase
      end
    end
  end

  assign busy  = (state_r != ST_IDLE);
  assign done  = done_r;
  assign p_out = p_out_r;
  assign err   = err_r;

endmodule : mmm_bit_serial
